// File: rtl/sipo_pkg.sv
// Shared helpers for the serial-in/parallel-out deserialiser: beat count,
// counter width and parameter legality.
package sipo_pkg;

    function automatic int beats(input int data_w, input int lanes);
        return (lanes > 0) ? data_w / lanes : 0;
    endfunction

    function automatic int cnt_w(input int n_beats);
        return (n_beats > 1) ? $clog2(n_beats) : 1;
    endfunction

    function automatic bit params_ok(input int data_w, input int lanes);
        return (lanes > 0) && (data_w % lanes == 0) && (data_w / lanes >= 2);
    endfunction

endpackage

// File: rtl/sipo_deser_shreg.sv
// Word-wide shift register; q_next is the post-shift value so the top can
// capture a completed word on the same edge as the final beat.
module sipo_shreg #(
    parameter int DATA_W    = 8,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic [LANES-1:0]  din,
    output logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] q_next
);

    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] sr_d;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign q_next = {sr_q[DATA_W-LANES-1:0], din};
        end else begin : g_lsb_first
            assign q_next = {din, sr_q[DATA_W-1:LANES]};
        end
    endgenerate

    always_comb begin
        sr_d = sr_q;
        if (shift_en) sr_d = q_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= sr_d;
    end

    assign q = sr_q;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserialiser: gathers LANES bits per beat into a
// DATA_W word and hands it out on a valid/ready port with full backpressure.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    clear_i,
    input  logic                                    in_valid_i,
    input  logic [LANES-1:0]                        in_data_i,
    output logic                                    in_ready_o,
    output logic [DATA_W-1:0]                       out_data_o,
    output logic                                    out_valid_o,
    input  logic                                    out_ready_i,
    output logic [cnt_w(beats(DATA_W, LANES))-1:0]  fill_o
);

    localparam int            BEATS     = beats(DATA_W, LANES);
    localparam int            CW        = cnt_w(BEATS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    generate
        if (!params_ok(DATA_W, LANES)) begin : g_param_err
            $fatal(1, "sipo_deser: DATA_W must be a multiple of LANES and DATA_W/LANES >= 2");
        end
    endgenerate

    logic [CW-1:0]     cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [DATA_W-1:0] sr_next;
    logic [DATA_W-1:0] sr_unused;
    logic              last_beat;
    logic              accept;

    assign last_beat = (cnt_q == LAST_BEAT);
    // Only the final beat can stall, and only behind an undrained word; the
    // same-cycle out_ready_i lets a drain and a completion share one edge.
    assign in_ready_o = !clear_i & (!last_beat | !out_valid_q | out_ready_i);
    assign accept     = in_valid_i & in_ready_o;

    sipo_shreg #(
        .DATA_W    (DATA_W),
        .LANES     (LANES),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (accept),
        .din      (in_data_i),
        .q        (sr_unused),
        .q_next   (sr_next)
    );

    always_comb begin
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (clear_i) begin
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            if (out_valid_q && out_ready_i) out_valid_d = 1'b0;
            if (accept) begin
                if (last_beat) begin
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = sr_next;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign fill_o      = cnt_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: directed scenarios plus a randomized run, checked
// against a bit-position reference model of the deserialiser.
module tb_sipo_deser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [0:0] in_data = '0;
    logic       in_ready, out_valid;
    logic [7:0] out_data;
    logic [2:0] fill;

    logic       b_clear = 1'b0, b_valid = 1'b0, b_oready = 1'b1;
    logic [1:0] b_data = '0;
    logic       b_iready, b_ovalid;
    logic [7:0] b_odata;
    logic [1:0] b_fill;

    int checks = 0;
    int failures = 0;

    // Reference model: bit k of a word is the k-th accepted bit (LSB-first).
    int         m_fill;
    logic [7:0] m_part, m_data;
    logic       m_vld;

    always #5 clk = ~clk;

    sipo_deser dut (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .in_valid_i(in_valid),
        .in_data_i(in_data), .in_ready_o(in_ready), .out_data_o(out_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .fill_o(fill)
    );

    sipo_deser #(.DATA_W(8), .LANES(2), .MSB_FIRST(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear_i(b_clear), .in_valid_i(b_valid),
        .in_data_i(b_data), .in_ready_o(b_iready), .out_data_o(b_odata),
        .out_valid_o(b_ovalid), .out_ready_i(b_oready), .fill_o(b_fill)
    );

    function automatic logic exp_ready();
        return !clear && (m_fill != 7 || !m_vld || out_ready);
    endfunction

    task automatic m_reset();
        m_fill = 0; m_part = '0; m_data = '0; m_vld = 1'b0;
    endtask

    task automatic drive(input logic v, input logic d, input logic r, input logic c);
        @(negedge clk);
        in_valid = v; in_data[0] = d; out_ready = r; clear = c;
        #1;
    endtask

    task automatic tick();
        logic acc, drn;
        acc = in_valid && exp_ready();
        drn = m_vld && out_ready;
        @(posedge clk);
        if (clear) begin
            m_fill = 0; m_vld = 1'b0;
        end else begin
            if (drn) m_vld = 1'b0;
            if (acc) begin
                m_part[m_fill] = in_data[0];
                if (m_fill == 7) begin
                    m_vld = 1'b1; m_data = m_part; m_fill = 0;
                end else begin
                    m_fill++;
                end
            end
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if (fill !== 3'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (b_ovalid !== 1'b0 || b_fill !== 2'd0) begin failures++; $display("FAIL reset_dut2 got=%b/%0d exp=0/0", b_ovalid, b_fill); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic test_lsb_pattern();
        bit seq[8] = '{0, 1, 0, 1, 1, 0, 0, 1};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, seq[i], 1'b1, 1'b0);
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lsb_early_valid beat=%0d got=%b exp=0", i, out_valid); end
            tick();
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h9A) begin failures++; $display("FAIL lsb_word got=%b/%h exp=1/9a", out_valid, out_data); end
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lsb_pulse_width got=%b exp=0", out_valid); end
    endtask

    task automatic test_msb_lanes2();
        logic [1:0] beats_in [4] = '{2'b10, 2'b11, 2'b00, 2'b01};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            b_valid = 1'b1; b_data = beats_in[i]; #1;
            checks++; if (b_fill !== 2'(i)) begin failures++; $display("FAIL msb_fill step=%0d got=%0d exp=%0d", i, b_fill, i); end
            checks++; if (b_iready !== 1'b1) begin failures++; $display("FAIL msb_ready step=%0d got=%b exp=1", i, b_iready); end
            tick();
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        b_valid = 1'b0; #1;
        checks++; if (b_fill !== 2'd0) begin failures++; $display("FAIL msb_fill_wrap got=%0d exp=0", b_fill); end
        checks++; if (b_ovalid !== 1'b1 || b_odata !== 8'hB1) begin failures++; $display("FAIL msb_word got=%b/%h exp=1/b1", b_ovalid, b_odata); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [7:0] w = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, w[i], 1'b1, 1'b0);
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'($urandom), 1'b0, 1'b0);
            checks++; if (in_ready !== (i < 7)) begin failures++; $display("FAIL bp_in_ready extra=%0d got=%b exp=%b", i, in_ready, (i < 7)); end
            checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin failures++; $display("FAIL bp_hold extra=%0d got=%b/%h exp=1/a5", i, out_valid, out_data); end
            tick();
        end
        drive(1'b1, 1'($urandom), 1'b1, 1'b0);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_data !== m_data) begin failures++; $display("FAIL bp_next_word got=%b/%h exp=1/%h", out_valid, out_data, m_data); end
        checks++; if (fill !== 3'd0) begin failures++; $display("FAIL bp_fill got=%0d exp=0", fill); end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_stream();
        for (int i = 0; i <= 32; i++) begin
            drive(i < 32, 1'($urandom), 1'b1, 1'b0);
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready cyc=%0d got=%b exp=1", i, in_ready); end
            checks++; if (out_valid !== (i > 0 && i % 8 == 0)) begin failures++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", i, out_valid, (i > 0 && i % 8 == 0)); end
            if (m_vld) begin
                checks++; if (out_data !== m_data) begin failures++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", i, out_data, m_data); end
            end
            tick();
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'($urandom), 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 1'($urandom), 1'b1, 1'b1);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL clear_in_ready got=%b exp=0", in_ready); end
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (fill !== 3'd0) begin failures++; $display("FAIL clear_fill got=%0d exp=0", fill); end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'($urandom), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_data !== m_data) begin failures++; $display("FAIL clear_clean_word got=%b/%h exp=1/%h", out_valid, out_data, m_data); end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clear_held_word got=%b exp=0", out_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 4) != 0, 1'($urandom), ($urandom % 3) != 0, ($urandom % 40) == 0);
            checks++; if (in_ready !== exp_ready()) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", i, in_ready, exp_ready()); end
            checks++; if (out_valid !== m_vld) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", i, out_valid, m_vld); end
            checks++; if (fill !== 3'(m_fill)) begin failures++; $display("FAIL rand_fill cyc=%0d got=%0d exp=%0d", i, fill, m_fill); end
            if (m_vld) begin
                checks++; if (out_data !== m_data) begin failures++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", i, out_data, m_data); end
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 1'($urandom), 1'b0, 1'b0);
            tick();
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin failures++; $display("FAIL arst_out got=%b/%h exp=0/00", out_valid, out_data); end
        checks++; if (fill !== 3'd0 || in_ready !== 1'b1) begin failures++; $display("FAIL arst_fill_ready got=%0d/%b exp=0/1", fill, in_ready); end
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'($urandom), 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_data !== m_data) begin failures++; $display("FAIL arst_new_word got=%b/%h exp=1/%h", out_valid, out_data, m_data); end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_lsb_pattern();
        test_msb_lanes2();
        test_backpressure();
        test_stream();
        test_clear();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
